alu_arbiter: RTL and testbench

Shares the single 64-bit ripple-carry `alu` between two requesters, e.g. the execute stage and the address/branch unit. Accepts operations over a valid/ready handshake with round-robin arbitration and holds the ALU operands stable for a programmable number of settle cycles. It then captures the result and flags into a per-requester response slot. This keeps the gate-delay ALU off the critical path of both clients.

---
 rtl/alu_arbiter.sv | 173 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two
// requesters; operands are held SETTLE cycles, then result/flags are captured.
module alu_arbiter #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned SETTLE = 4
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_cntrl,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_cntrl,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic [3:0]       rsp0_flags,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic [3:0]       rsp1_flags,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_cntrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_negative,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_carry_out
);

    typedef enum logic {
        IDLE,
        EVAL
    } state_t;

    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic             owner_q, owner_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_cntrl_q, alu_cntrl_d;
    logic             rsp0_valid_q, rsp0_valid_d;
    logic [WIDTH-1:0] rsp0_result_q, rsp0_result_d;
    logic [3:0]       rsp0_flags_q, rsp0_flags_d;
    logic             rsp1_valid_q, rsp1_valid_d;
    logic [WIDTH-1:0] rsp1_result_q, rsp1_result_d;
    logic [3:0]       rsp1_flags_q, rsp1_flags_d;

    logic       elig0, elig1, grant0, grant1, hs0, hs1, arith;
    logic [3:0] flags_cap;

    always_comb begin
        elig0  = req0_valid & ~rsp0_valid_q;
        elig1  = req1_valid & ~rsp1_valid_q;
        grant0 = elig0 & (~elig1 | ~prio_q);
        grant1 = elig1 & (~elig0 | prio_q);
    end

    // Gated by reset so nothing is offered while the block is held in reset.
    assign req0_ready = reset & (state_q == IDLE) & grant0;
    assign req1_ready = reset & (state_q == IDLE) & grant1;
    assign hs0        = req0_valid & req0_ready;
    assign hs1        = req1_valid & req1_ready;

    // Overflow/carry only carry meaning for add (010) and sub (011).
    assign arith     = (alu_cntrl_q[2:1] == 2'b01);
    assign flags_cap = {alu_negative, alu_zero, alu_overflow & arith, alu_carry_out & arith};

    always_comb begin
        state_d       = state_q;
        prio_d        = prio_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_cntrl_d   = alu_cntrl_q;
        rsp0_valid_d  = rsp0_valid_q;
        rsp0_result_d = rsp0_result_q;
        rsp0_flags_d  = rsp0_flags_q;
        rsp1_valid_d  = rsp1_valid_q;
        rsp1_result_d = rsp1_result_q;
        rsp1_flags_d  = rsp1_flags_q;

        if (rsp0_valid_q && rsp0_ready) rsp0_valid_d = 1'b0;
        if (rsp1_valid_q && rsp1_ready) rsp1_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (hs0 || hs1) begin
                    alu_a_d     = hs1 ? req1_a : req0_a;
                    alu_b_d     = hs1 ? req1_b : req0_b;
                    alu_cntrl_d = hs1 ? req1_cntrl : req0_cntrl;
                    owner_d     = hs1;
                    prio_d      = ~hs1;
                    cnt_d       = 8'(SETTLE - 1);
                    state_d     = EVAL;
                end
            end
            EVAL: begin
                if (cnt_q == 8'd0) begin
                    if (owner_q) begin
                        rsp1_valid_d  = 1'b1;
                        rsp1_result_d = alu_result;
                        rsp1_flags_d  = flags_cap;
                    end else begin
                        rsp0_valid_d  = 1'b1;
                        rsp0_result_d = alu_result;
                        rsp0_flags_d  = flags_cap;
                    end
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            prio_q        <= 1'b0;
            owner_q       <= 1'b0;
            cnt_q         <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_cntrl_q   <= '0;
            rsp0_valid_q  <= 1'b0;
            rsp0_result_q <= '0;
            rsp0_flags_q  <= '0;
            rsp1_valid_q  <= 1'b0;
            rsp1_result_q <= '0;
            rsp1_flags_q  <= '0;
        end else begin
            state_q       <= state_d;
            prio_q        <= prio_d;
            owner_q       <= owner_d;
            cnt_q         <= cnt_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_cntrl_q   <= alu_cntrl_d;
            rsp0_valid_q  <= rsp0_valid_d;
            rsp0_result_q <= rsp0_result_d;
            rsp0_flags_q  <= rsp0_flags_d;
            rsp1_valid_q  <= rsp1_valid_d;
            rsp1_result_q <= rsp1_result_d;
            rsp1_flags_q  <= rsp1_flags_d;
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_cntrl   = alu_cntrl_q;
    assign rsp0_valid  = rsp0_valid_q;
    assign rsp0_result = rsp0_result_q;
    assign rsp0_flags  = rsp0_flags_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp1_result = rsp1_result_q;
    assign rsp1_flags  = rsp1_flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural 64-bit ALU attached.
module tb_alu_arbiter;

    localparam int W      = 64;
    localparam int SETTLE = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic [2:0]    req0_cntrl, req1_cntrl;
    logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [W-1:0]  rsp0_result, rsp1_result;
    logic [3:0]    rsp0_flags, rsp1_flags;
    logic [W-1:0]  alu_a, alu_b, alu_result;
    logic [2:0]    alu_cntrl;
    logic          alu_negative, alu_zero, alu_overflow, alu_carry_out, alu_c_raw;
    logic          force_cy;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [67:0]   q0[$];
    logic [67:0]   q1[$];

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W), .SETTLE(SETTLE)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_cntrl(req0_cntrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_cntrl(req1_cntrl),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_flags(rsp0_flags),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_flags(rsp1_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cntrl(alu_cntrl), .alu_result(alu_result),
        .alu_negative(alu_negative), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .alu_carry_out(alu_carry_out)
    );

    // Raw ALU behaviour {n,z,v,c,result}; logic ops drive a junk overflow of 1.
    function automatic logic [67:0] alu_raw(input logic [63:0] a, input logic [63:0] b,
                                            input logic [2:0] op);
        logic [64:0] s;
        logic [63:0] r;
        logic        v, c;
        v = 1'b1;
        c = 1'b0;
        case (op)
            3'b000: r = b;
            3'b010: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[63:0]; c = s[64];
                v = (a[63] == b[63]) && (r[63] != a[63]);
            end
            3'b011: begin
                s = {1'b0, a} + {1'b0, ~b} + 65'd1;
                r = s[63:0]; c = s[64];
                v = (a[63] != b[63]) && (r[63] != a[63]);
            end
            3'b100: r = a & b;
            3'b101: r = a | b;
            3'b110: r = a ^ b;
            default: r = a;
        endcase
        return {r[63], (r == 64'd0), v, c, r};
    endfunction

    function automatic logic [67:0] expect_of(input logic [63:0] a, input logic [63:0] b,
                                              input logic [2:0] op);
        logic [67:0] e;
        e = alu_raw(a, b, op);
        if (!(op == 3'b010 || op == 3'b011)) e[65:64] = 2'b00;
        return e;
    endfunction

    assign {alu_negative, alu_zero, alu_overflow, alu_c_raw, alu_result} = alu_raw(alu_a, alu_b, alu_cntrl);
    assign alu_carry_out = alu_c_raw | force_cy;

    task automatic drive(input int r, input logic [63:0] a, input logic [63:0] b, input logic [2:0] op);
        if (r == 0) begin
            req0_a = a; req0_b = b; req0_cntrl = op; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_cntrl = op; req1_valid = 1'b1;
        end
    endtask

    // Returns just after the handshake edge when ok, else at a falling edge.
    task automatic wait_hs(input int r, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            #1;
            if ((r == 0) ? req0_ready : req1_ready) begin
                ok = 1'b1;
                @(posedge clk);
                break;
            end
            @(negedge clk);
        end
    endtask

    // Called at the falling edge after the handshake; edges = clock edges since it.
    task automatic wait_rsp(input int r, input int max, output bit ok, output int edges);
        ok = 1'b0;
        edges = 0;
        for (int i = 0; i < max; i++) begin
            if ((r == 0) ? rsp0_valid : rsp1_valid) begin
                ok = 1'b1;
                edges = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_one(input int r, input logic [63:0] a, input logic [63:0] b,
                           input logic [2:0] op, output bit hs_ok, output bit rsp_ok,
                           output int edges);
        drive(r, a, b, op);
        wait_hs(r, 20, hs_ok);
        if (hs_ok) @(negedge clk);
        if (r == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        wait_rsp(r, 20, rsp_ok, edges);
    endtask

    task automatic pop_rsp(input int r);
        if (r == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
    endtask

    task automatic do_reset();
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
        end
        n_checks++;
        if ({alu_a, alu_b, alu_cntrl} !== '0) begin
            n_fail++; $display("FAIL reset_alu_ops: got %h/%h/%b expected 0", alu_a, alu_b, alu_cntrl);
        end
        n_checks++;
        if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
            n_fail++; $display("FAIL reset_rsp_valid: got %b expected 00", {rsp0_valid, rsp1_valid});
        end
        n_checks++;
        if ({rsp0_result, rsp0_flags, rsp1_result, rsp1_flags} !== '0) begin
            n_fail++; $display("FAIL reset_slots: got %h %b %h %b expected 0",
                               rsp0_result, rsp0_flags, rsp1_result, rsp1_flags);
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add_overflow();
        bit hs_ok, rsp_ok;
        int edges;
        logic [67:0] e;
        q0.push_back({4'b1010, 64'h8000_0000_0000_0000});
        run_one(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, hs_ok, rsp_ok, edges);
        n_checks++;
        if (!hs_ok) begin n_fail++; $display("FAIL add_handshake: got none expected handshake"); end
        n_checks++;
        if (!rsp_ok || edges != SETTLE) begin
            n_fail++; $display("FAIL add_latency: got ok=%0d edges=%0d expected %0d", rsp_ok, edges, SETTLE);
        end
        e = q0.pop_front();
        n_checks++;
        if ({rsp0_flags, rsp0_result} !== e) begin
            n_fail++; $display("FAIL add_result: got %b %h expected %b %h", rsp0_flags, rsp0_result, e[67:64], e[63:0]);
        end
        n_checks++;
        if ({alu_a, alu_b, alu_cntrl} !== {64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010}) begin
            n_fail++; $display("FAIL add_operand_hold: got %h %h %b expected held operands", alu_a, alu_b, alu_cntrl);
        end
        pop_rsp(0);
        n_checks++;
        if (rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL add_pop: got %b expected 0", rsp0_valid); end
    endtask

    task automatic test_round_robin();
        logic [2:0]  op_tbl [4];
        logic [67:0] e;
        logic [1:0]  exp_g;
        int          hs, last;
        op_tbl[0] = 3'b010; op_tbl[1] = 3'b011; op_tbl[2] = 3'b110; op_tbl[3] = 3'b101;
        do_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        hs = 0; last = -1; exp_g = 2'b01;
        for (int c = 0; c < 80 && hs < 8; c++) begin
            if (rsp0_valid) begin
                e = (q0.size() > 0) ? q0.pop_front() : '1;
                n_checks++;
                if ({rsp0_flags, rsp0_result} !== e) begin
                    n_fail++; $display("FAIL rr_rsp0: got %b %h expected %b %h", rsp0_flags, rsp0_result, e[67:64], e[63:0]);
                end
            end
            if (rsp1_valid) begin
                e = (q1.size() > 0) ? q1.pop_front() : '1;
                n_checks++;
                if ({rsp1_flags, rsp1_result} !== e) begin
                    n_fail++; $display("FAIL rr_rsp1: got %b %h expected %b %h", rsp1_flags, rsp1_result, e[67:64], e[63:0]);
                end
            end
            drive(0, {$urandom, $urandom}, {$urandom, $urandom}, op_tbl[$urandom_range(0, 3)]);
            drive(1, {$urandom, $urandom}, {$urandom, $urandom}, op_tbl[$urandom_range(0, 3)]);
            #1;
            if (req0_ready || req1_ready) begin
                n_checks++;
                if ({req1_ready, req0_ready} !== exp_g) begin
                    n_fail++; $display("FAIL rr_grant: got %b expected %b", {req1_ready, req0_ready}, exp_g);
                end
                if (last >= 0) begin
                    n_checks++;
                    if (c - last != SETTLE + 1) begin
                        n_fail++; $display("FAIL rr_spacing: got %0d expected %0d", c - last, SETTLE + 1);
                    end
                end
                if (req0_ready) q0.push_back(expect_of(req0_a, req0_b, req0_cntrl));
                else            q1.push_back(expect_of(req1_a, req1_b, req1_cntrl));
                last = c;
                exp_g = ~exp_g;
                hs++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (hs != 8) begin n_fail++; $display("FAIL rr_count: got %0d expected 8", hs); end
        for (int c = 0; c < 12; c++) begin
            req0_valid = 1'b0; req1_valid = 1'b0;
            if (rsp0_valid) begin
                e = (q0.size() > 0) ? q0.pop_front() : '1;
                n_checks++;
                if ({rsp0_flags, rsp0_result} !== e) begin
                    n_fail++; $display("FAIL rr_drain0: got %b %h expected %b %h", rsp0_flags, rsp0_result, e[67:64], e[63:0]);
                end
            end
            if (rsp1_valid) begin
                e = (q1.size() > 0) ? q1.pop_front() : '1;
                n_checks++;
                if ({rsp1_flags, rsp1_result} !== e) begin
                    n_fail++; $display("FAIL rr_drain1: got %b %h expected %b %h", rsp1_flags, rsp1_result, e[67:64], e[63:0]);
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++; $display("FAIL rr_outstanding: got %0d/%0d expected 0/0", q0.size(), q1.size());
        end
        q0.delete(); q1.delete();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bit hs_ok, rsp_ok, saw_ready, moved;
        int edges;
        logic [67:0] e;
        rsp1_ready = 1'b0;
        q1.push_back({4'b0100, 64'd0});
        drive(1, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 3'b110);
        wait_hs(1, 20, hs_ok);
        n_checks++;
        if (!hs_ok) begin n_fail++; $display("FAIL bp_handshake: got none expected handshake"); end
        @(negedge clk);
        drive(1, 64'd1, 64'd2, 3'b110);
        wait_rsp(1, 20, rsp_ok, edges);
        n_checks++;
        if (!rsp_ok || edges != SETTLE) begin
            n_fail++; $display("FAIL bp_latency: got ok=%0d edges=%0d expected %0d", rsp_ok, edges, SETTLE);
        end
        e = q1.pop_front();
        n_checks++;
        if ({rsp1_flags, rsp1_result} !== e) begin
            n_fail++; $display("FAIL bp_xor_result: got %b %h expected %b %h", rsp1_flags, rsp1_result, e[67:64], e[63:0]);
        end
        saw_ready = 1'b0; moved = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (req1_ready) saw_ready = 1'b1;
            if ({rsp1_valid, rsp1_flags, rsp1_result} !== {1'b1, e}) moved = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (saw_ready) begin n_fail++; $display("FAIL bp_blocked: got ready=1 expected 0 while slot full"); end
        n_checks++;
        if (moved) begin n_fail++; $display("FAIL bp_slot_stable: got changed slot expected held"); end
        rsp1_ready = 1'b1;
        #1;
        n_checks++;
        if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL bp_no_bypass: got %b expected 0", req1_ready); end
        @(negedge clk);
        rsp1_ready = 1'b0;
        #1;
        n_checks++;
        if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL bp_reaccept: got %b expected 1", req1_ready); end
        q1.push_back({4'b0000, 64'd3});
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        wait_rsp(1, 20, rsp_ok, edges);
        e = q1.pop_front();
        n_checks++;
        if (!rsp_ok || {rsp1_flags, rsp1_result} !== e) begin
            n_fail++; $display("FAIL bp_second: got %b %h expected %b %h", rsp1_flags, rsp1_result, e[67:64], e[63:0]);
        end
        pop_rsp(1);
    endtask

    task automatic test_and_mask();
        bit hs_ok, rsp_ok;
        int edges;
        logic [67:0] e;
        force_cy = 1'b1;
        q0.push_back({4'b0000, 64'h0F0F_0000});
        run_one(0, 64'hFFFF_0000, 64'h0F0F_0F0F, 3'b100, hs_ok, rsp_ok, edges);
        e = q0.pop_front();
        n_checks++;
        if (!hs_ok || !rsp_ok || edges != SETTLE) begin
            n_fail++; $display("FAIL and_timing: got hs=%0d rsp=%0d edges=%0d expected 1 1 %0d", hs_ok, rsp_ok, edges, SETTLE);
        end
        n_checks++;
        if ({rsp0_flags, rsp0_result} !== e) begin
            n_fail++; $display("FAIL and_masked: got %b %h expected %b %h", rsp0_flags, rsp0_result, e[67:64], e[63:0]);
        end
        pop_rsp(0);
        force_cy = 1'b0;
    endtask

    task automatic test_reset_mid_eval();
        bit hs_ok, rsp_ok, leaked;
        int edges;
        logic [67:0] e;
        drive(0, 64'd9, 64'd3, 3'b011);
        wait_hs(0, 20, hs_ok);
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({alu_a, alu_b, alu_cntrl} !== '0) begin
            n_fail++; $display("FAIL mid_reset_ops: got %h %h %b expected 0", alu_a, alu_b, alu_cntrl);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        leaked = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rsp0_valid || rsp1_valid) leaked = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (!hs_ok || leaked) begin
            n_fail++; $display("FAIL mid_reset_discard: got hs=%0d leaked=%0d expected 1 0", hs_ok, leaked);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        n_checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            n_fail++; $display("FAIL mid_reset_prio: got %b expected 01", {req1_ready, req0_ready});
        end
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        q1.push_back({4'b0000, 64'd13});
        run_one(1, 64'd10, 64'd3, 3'b010, hs_ok, rsp_ok, edges);
        e = q1.pop_front();
        n_checks++;
        if (!hs_ok || !rsp_ok || {rsp1_flags, rsp1_result} !== e) begin
            n_fail++; $display("FAIL mid_reset_req1: got %b %h expected %b %h", rsp1_flags, rsp1_result, e[67:64], e[63:0]);
        end
        pop_rsp(1);
    endtask

    task automatic test_sub_pass();
        bit hs_ok, rsp_ok;
        int edges;
        logic [67:0] e;
        q0.push_back({4'b0101, 64'd0});
        q0.push_back({4'b1000, 64'h8000_0000_0000_0000});
        run_one(0, 64'd5, 64'd5, 3'b011, hs_ok, rsp_ok, edges);
        e = q0.pop_front();
        n_checks++;
        if (!hs_ok || !rsp_ok || {rsp0_flags, rsp0_result} !== e) begin
            n_fail++; $display("FAIL sub_zero: got %b %h expected %b %h", rsp0_flags, rsp0_result, e[67:64], e[63:0]);
        end
        pop_rsp(0);
        run_one(0, 64'h123, 64'h8000_0000_0000_0000, 3'b000, hs_ok, rsp_ok, edges);
        e = q0.pop_front();
        n_checks++;
        if (!hs_ok || !rsp_ok || {rsp0_flags, rsp0_result} !== e) begin
            n_fail++; $display("FAIL pass_b: got %b %h expected %b %h", rsp0_flags, rsp0_result, e[67:64], e[63:0]);
        end
        pop_rsp(0);
    endtask

    initial begin
        reset = 1'b1;
        force_cy = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_cntrl = '0;
        req1_a = '0; req1_b = '0; req1_cntrl = '0;
        #1;
        test_reset();
        test_add_overflow();
        test_round_robin();
        test_backpressure();
        test_and_mask();
        test_reset_mid_eval();
        test_sub_pass();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
